// File: rtl/fmap_feeder.sv
// Purpose: deserialises a weight block and then one feature-map column at a time into wide packed buses for the accelerator.
// Latency: valid_o rises the cycle after the last word of a column is accepted and drops the cycle after the handshake.
// Backpressure: s_ready is low while a column is presented; the column is held indefinitely until ready_i.
module fmap_feeder #(
    parameter int HIT     = 56,
    parameter int WID     = 56,
    parameter int WHT_NUM = 10,
    parameter int DW      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DW-1:0]         s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  abort,
    output logic [HIT*DW-1:0]     fmap_o,
    output logic [WHT_NUM*DW-1:0] wht_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_col_o
);

    // One word counter serves both the weight phase and the column phase,
    // so it is sized for whichever of the two is longer.
    localparam int WC_MAX = (HIT > WHT_NUM) ? HIT : WHT_NUM;
    localparam int WC_W   = (WC_MAX > 1) ? $clog2(WC_MAX) : 1;
    localparam int CC_W   = (WID > 1) ? $clog2(WID) : 1;

    localparam logic [WC_W-1:0] WHT_LAST = WC_W'(WHT_NUM - 1);
    localparam logic [WC_W-1:0] HIT_LAST = WC_W'(HIT - 1);
    localparam logic [CC_W-1:0] COL_LAST = CC_W'(WID - 1);

    typedef enum logic [1:0] {
        LOAD_WHT = 2'd0,
        LOAD_COL = 2'd1,
        PRESENT  = 2'd2
    } state_t;

    state_t            state;
    logic [WC_W-1:0]   word_cnt;
    logic [CC_W-1:0]   col_cnt;
    logic              take;

    // A word is consumed only when the feeder is actually listening.
    assign take = s_valid && s_ready;

    // The final column of a channel is flagged only while it is being presented.
    assign last_col_o = valid_o && (col_cnt == COL_LAST);

    // Feeder FSM: loads weights, loads columns, presents each column; abort
    // restarts the channel but keeps the already loaded buffer contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LOAD_WHT;
            word_cnt <= '0;
            col_cnt  <= '0;
            valid_o  <= 1'b0;
            s_ready  <= 1'b1;
            fmap_o   <= '0;
            wht_o    <= '0;
        end else if (abort) begin
            // Any word or column handshake in this cycle is dropped from the
            // feeder's point of view; the downstream keeps what it took.
            state    <= LOAD_WHT;
            word_cnt <= '0;
            col_cnt  <= '0;
            valid_o  <= 1'b0;
            s_ready  <= 1'b1;
        end else begin
            case (state)
                LOAD_WHT: begin
                    if (take) begin
                        for (int k = 0; k < WHT_NUM; k++) begin
                            if (word_cnt == WC_W'(k)) begin
                                wht_o[k*DW +: DW] <= s_data;
                            end
                        end
                        if (word_cnt == WHT_LAST) begin
                            word_cnt <= '0;
                            state    <= LOAD_COL;
                        end else begin
                            word_cnt <= word_cnt + WC_W'(1);
                        end
                    end
                end

                LOAD_COL: begin
                    if (take) begin
                        for (int k = 0; k < HIT; k++) begin
                            if (word_cnt == WC_W'(k)) begin
                                fmap_o[k*DW +: DW] <= s_data;
                            end
                        end
                        if (word_cnt == HIT_LAST) begin
                            word_cnt <= '0;
                            state    <= PRESENT;
                            valid_o  <= 1'b1;
                            s_ready  <= 1'b0;
                        end else begin
                            word_cnt <= word_cnt + WC_W'(1);
                        end
                    end
                end

                PRESENT: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        s_ready <= 1'b1;
                        if (col_cnt == COL_LAST) begin
                            col_cnt <= '0;
                            state   <= LOAD_WHT;
                        end else begin
                            col_cnt <= col_cnt + CC_W'(1);
                            state   <= LOAD_COL;
                        end
                    end
                end

                default: begin
                    state    <= LOAD_WHT;
                    word_cnt <= '0;
                    col_cnt  <= '0;
                    valid_o  <= 1'b0;
                    s_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fmap_feeder.sv
// Bench for fmap_feeder: directed channel, backpressure, wrap, gapped, abort and reset scenarios.
// The reference tracks how many words of the current channel were accepted and how many columns were delivered.
module tb_fmap_feeder;

    localparam int HIT     = 56;
    localparam int WID     = 56;
    localparam int WHT_NUM = 10;
    localparam int DW      = 32;

    logic                  clk;
    logic                  rst;
    logic [DW-1:0]         s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic                  abort;
    logic [HIT*DW-1:0]     fmap_o;
    logic [WHT_NUM*DW-1:0] wht_o;
    logic                  valid_o;
    logic                  ready_i;
    logic                  last_col_o;

    fmap_feeder #(.HIT(HIT), .WID(WID), .WHT_NUM(WHT_NUM), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .abort(abort),
        .fmap_o(fmap_o), .wht_o(wht_o),
        .valid_o(valid_o), .ready_i(ready_i), .last_col_o(last_col_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference: expected buffer contents plus channel progress counters.
    logic [DW-1:0] m_wht  [WHT_NUM];
    logic [DW-1:0] m_fmap [HIT];
    int            n_acc;      // words accepted since channel start
    int            delivered;  // columns handed over in this channel

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic m_valid();
        return n_acc == WHT_NUM + HIT * (delivered + 1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < WHT_NUM; k++) m_wht[k] = '0;
        for (int k = 0; k < HIT; k++) m_fmap[k] = '0;
        n_acc     = 0;
        delivered = 0;
    endtask

    task automatic check_outputs();
        int  wi;
        int  fi;
        logic ev;
        ev = m_valid();
        wi = 0;
        fi = 0;
        for (int k = WHT_NUM - 1; k >= 0; k--) if (wht_o[k*DW +: DW] !== m_wht[k]) wi = k;
        for (int k = HIT - 1; k >= 0; k--) if (fmap_o[k*DW +: DW] !== m_fmap[k]) fi = k;
        chk("valid_o", {31'd0, valid_o}, {31'd0, ev});
        chk("s_ready", {31'd0, s_ready}, {31'd0, !ev});
        chk("last_col_o", {31'd0, last_col_o}, {31'd0, ev && (delivered == WID - 1)});
        chk($sformatf("wht_o[%0d]", wi), wht_o[wi*DW +: DW], m_wht[wi]);
        chk($sformatf("fmap_o[%0d]", fi), fmap_o[fi*DW +: DW], m_fmap[fi]);
    endtask

    // Drive one cycle of inputs, check current outputs, advance the reference to the next edge.
    task automatic step(input logic sv, input logic [DW-1:0] d, input logic rdy, input logic ab);
        logic ev;
        s_valid = sv;
        s_data  = d;
        ready_i = rdy;
        abort   = ab;
        check_outputs();
        ev = m_valid();
        if (ab) begin
            n_acc     = 0;
            delivered = 0;
        end else if (ev) begin
            if (rdy) begin
                delivered++;
                if (delivered == WID) begin
                    n_acc     = 0;
                    delivered = 0;
                end
            end
        end else if (sv) begin
            if (n_acc < WHT_NUM) m_wht[n_acc] = d;
            else m_fmap[(n_acc - WHT_NUM) % HIT] = d;
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; ready_i = 1'b0; abort = 1'b0;
        model_reset();
        #3;
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full channel at full rate: weights 0x100.., column c carries (c<<8)|k.
        for (int k = 0; k < WHT_NUM; k++) step(1'b1, DW'(32'h100 + k), 1'b1, 1'b0);
        for (int c = 0; c < WID; c++) begin
            for (int k = 0; k < HIT; k++) step(1'b1, DW'((c << 8) | k), 1'b1, 1'b0);
            chk("present_valid", {31'd0, valid_o}, 32'd1);
            chk("last_col_at", {31'd0, last_col_o}, {31'd0, c == WID - 1});
            if (c == 0) begin
                chk("ch_wht0", wht_o[DW-1:0], 32'h100);
                chk("ch_fmap55", fmap_o[55*DW +: DW], 32'd55);
                // Backpressure: s_valid is high but must be ignored while held.
                for (int i = 0; i < 20; i++) step(1'b1, $urandom, 1'b0, 1'b0);
                chk("bp_fmap0_held", fmap_o[DW-1:0], 32'd0);
            end
            step(1'b1, $urandom, 1'b1, 1'b0);
            chk("after_hs_valid", {31'd0, valid_o}, 32'd0);
        end
        // Wrap: next word is weight 0 of a new channel.
        step(1'b1, 32'hABC, 1'b1, 1'b0);
        chk("wrap_wht0", wht_o[DW-1:0], 32'hABC);

        // Gapped, randomly backpressured traffic with rare aborts.
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 199) == 0));

        // Abort after 30 column words, with a word offered in the same cycle.
        step(1'b0, '0, 1'b1, 1'b1);
        for (int k = 0; k < WHT_NUM; k++) step(1'b1, $urandom, 1'b1, 1'b0);
        for (int k = 0; k < 30; k++) step(1'b1, DW'(32'h7000 + k), 1'b1, 1'b0);
        step(1'b1, 32'hDEAD, 1'b1, 1'b1);
        chk("abort_s_ready", {31'd0, s_ready}, 32'd1);
        chk("abort_fmap30_kept", fmap_o[30*DW +: DW], m_fmap[30]);
        step(1'b1, 32'h5A5A, 1'b1, 1'b0);
        chk("abort_wht0", wht_o[DW-1:0], 32'h5A5A);

        // Load to PRESENT, then hit reset between edges.
        for (int k = 1; k < WHT_NUM; k++) step(1'b1, $urandom, 1'b1, 1'b0);
        for (int k = 0; k < HIT; k++) step(1'b1, DW'(32'h900 + k), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("pre_rst_valid", {31'd0, valid_o}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid_async", {31'd0, valid_o}, 32'd0);
        chk("rst_fmap0_async", fmap_o[DW-1:0], 32'd0);
        chk("rst_fmap_or", {31'd0, |fmap_o}, 32'd0);
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
        step(1'b1, 32'h1234, 1'b1, 1'b0);
        chk("post_rst_wht0", wht_o[DW-1:0], 32'h1234);
        for (int k = 0; k < 4; k++) step(1'b1, $urandom, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
